// File: rtl/button_press_gen_pkg.sv
// Shared types and defaults for the button press generator.
// Holds the FSM state enum, default GAP/LEN_W and the length-0-as-1 rule.
package button_press_pkg;

  localparam int DEF_LEN_W = 8;
  localparam int DEF_GAP   = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRESS = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  // Effective press length: a request of 0 still yields one high cycle.
  function automatic int unsigned len_eff(int unsigned len);
    return (len == 32'd0) ? 32'd1 : len;
  endfunction

endpackage

// File: rtl/button_press_gen_if.sv
// Request handshake plus generated button outputs.
// master: req_valid/req_len out; slave: req_ready, y, busy, done out.
interface button_press_gen_if
  import button_press_pkg::*;
#(
  parameter int LEN_W = DEF_LEN_W
);
  logic             req_valid;
  logic [LEN_W-1:0] req_len;
  logic             req_ready;
  logic             y;
  logic             busy;
  logic             done;

  modport master (
    output req_valid,
    output req_len,
    input  req_ready,
    input  y,
    input  busy,
    input  done
  );

  modport slave (
    input  req_valid,
    input  req_len,
    output req_ready,
    output y,
    output busy,
    output done
  );
endinterface

// File: rtl/button_press_gen_req_buf.sv
// press_req_buf: one-entry valid/data holding register for a press length.
// Ports: clk, rst (sync, active-high), push/push_data, pop, valid/data.
module press_req_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         valid,
  output logic [W-1:0] data
);
  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (pop) valid_d = 1'b0;
    if (push) begin
      valid_d = 1'b1;
      data_d  = push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;
endmodule

// File: rtl/button_press_gen.sv
// Turns accepted press requests into a registered high pulse on y of the
// requested length, followed by GAP forced low cycles (done on the first).
// Ports: clk, rst (sync, active-high), bus (button_press_gen_if.slave):
//   req_valid/req_len/req_ready handshake, y, busy, done outputs.
// Macro BUTTON_PRESS_GEN_QUEUE_EN adds a one-entry buffer so a request
// taken during PRESS/GAP launches right at the end of GAP.
module button_press_gen
  import button_press_pkg::*;
#(
  parameter int LEN_W = DEF_LEN_W,
  parameter int GAP   = DEF_GAP
) (
  input  logic               clk,
  input  logic               rst,
  button_press_gen_if.slave  bus
);
  localparam int CNT_W = (LEN_W > 8) ? LEN_W : 8;
  typedef logic [CNT_W-1:0] cnt_t;
  localparam cnt_t GAP_LOAD = cnt_t'(GAP - 1);

  state_e           state_q, state_d;
  cnt_t             cnt_q, cnt_d;
  logic             y_q, y_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             accept;
  logic             launch;
  logic [LEN_W-1:0] launch_len;
  logic             buf_valid;
  logic [LEN_W-1:0] buf_len;

`ifdef BUTTON_PRESS_GEN_QUEUE_EN
  logic buf_push, buf_pop;

  // In IDLE (buffer always empty there) or at a GAP end with an empty
  // buffer, the incoming request launches directly; otherwise it waits.
  assign buf_push = accept && !launch;
  assign buf_pop  = launch && buf_valid;

  press_req_buf #(
    .W (LEN_W)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (buf_push),
    .push_data (bus.req_len),
    .pop       (buf_pop),
    .valid     (buf_valid),
    .data      (buf_len)
  );

  assign bus.req_ready = !buf_valid;
`else
  assign buf_valid     = 1'b0;
  assign buf_len       = '0;
  assign bus.req_ready = (state_q == ST_IDLE);
`endif

  assign accept = bus.req_valid && bus.req_ready;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    done_d     = 1'b0;
    launch     = 1'b0;
    launch_len = bus.req_len;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) launch = 1'b1;
      end
      ST_PRESS: begin
        if (cnt_q == '0) begin
          state_d = ST_GAP;
          cnt_d   = GAP_LOAD;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_GAP: begin
        if (cnt_q == '0) begin
          if (buf_valid) begin
            launch     = 1'b1;
            launch_len = buf_len;
          end else if (accept) begin
            launch = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    if (launch) begin
      state_d = ST_PRESS;
      cnt_d   = cnt_t'(len_eff(32'(launch_len)) - 32'd1);
    end
    y_d    = (state_d == ST_PRESS);
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      y_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.y    = y_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
endmodule

// File: doc/button_press_gen.md
# button_press_gen

Generates the button-level waveform consumed by the press-event detector: converts accepted press requests into a clean, registered high pulse on `y` of programmed length, followed by a guaranteed low gap. Sits on the stimulus/driver side of the button path, in front of the detector in self-test and emulation builds. Requests arrive over a valid/ready handshake, with optional one-entry buffering for back-to-back presses.

## Interface
- `LEN_W`, 8: width of the press-length field.
- `GAP`, 2: low cycles forced after every press; legal range 1..255.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `req_valid`  in  1  press request present.
- `req_len`  in  LEN_W  press length in cycles; 0 treated as 1.
- `req_ready`  out  1  request accepted when `req_valid && req_ready` at a rising edge.
- `y`  out  1  generated button level, registered.
- `busy`  out  1  high in PRESS or GAP, registered.
- `done`  out  1  one-cycle pulse in the first GAP cycle of each press.

## Operation
- States (shared enum): IDLE, PRESS, GAP.
- IDLE: `y`=0, `busy`=0. On accept, load the down-counter with `max(req_len,1)-1` and go to PRESS.
- PRESS: `y`=1. Counter decrements each cycle. When it reads 0, load `GAP-1` and go to GAP.
- GAP: `y`=0; `done`=1 in the first GAP cycle only. When the counter reads 0, go to IDLE, or go straight to PRESS if a buffered request exists (macro on).
- `req_ready` is combinational from state and buffer occupancy only; it never depends on `req_valid`.
- A request is captured whole (`req_len` sampled at the accept edge); later changes on `req_len` are ignored.
- Down-counter width is `max(LEN_W,8)`; no wrap. Loads happen only on state entry.
- Reset: state IDLE, counter 0, buffer empty. Outputs `y`=0, `busy`=0, `done`=0, `req_ready`=1.
- Reset mid-PRESS or mid-GAP: `y` is low from the cycle after the reset edge. No `done` is emitted and any buffered request is discarded.
- `rst` and `req_valid` high together: reset wins and the request is not accepted.

## Timing
- Accept at edge k with length L: `y`=1 in cycles k+1..k+L. `done` and the first GAP cycle fall at k+L+1. GAP spans k+L+1..k+L+GAP.
- Without buffering: return to IDLE at k+L+GAP+1; the earliest next accept is that edge, so the next rise is at k+L+GAP+2.
- With buffering: the next press rises at k+L+GAP+1, giving exactly GAP low cycles between presses.
- `busy` equals the PRESS|GAP state; it is registered, zero latency relative to `y`.

## Configuration
- `BUTTON_PRESS_GEN_QUEUE_EN` defined:
  - One-entry request buffer is present.
  - `req_ready`=1 whenever the buffer is empty, in any state.
  - The request accepted in IDLE goes directly to PRESS and does not occupy the buffer.
  - Requests accepted in PRESS/GAP are held in the buffer and launched at the end of GAP.
- Undefined:
  - No buffer.
  - `req_ready`=1 only in IDLE.

## Structure
- Package `button_press_pkg` holds:
  - the state enum typedef (IDLE, PRESS, GAP);
  - the default `GAP` and `LEN_W` constants;
  - the length-0-as-1 rule as a function.
- Sub-module `press_req_buf` (one-entry valid/data register) is instantiated only under the macro.
- FSM and counter live in the top.

## Test plan
- Reset, then request with `req_len`=3 and `GAP`=2 at edge 0:
  - `y` high in cycles 1–3 and low in 4–5;
  - `done` high only in cycle 4;
  - `req_ready` back to 1 at cycle 6.
- `req_len`=0: `y` high for exactly 1 cycle, `done` pulses once.
- Macro off, `req_valid` held high with lengths 2 then 4: second accept only when IDLE; gap between presses = GAP+1 low cycles.
- Macro on, same stimulus: second request is accepted during PRESS; gap between presses is exactly 2 low cycles and `req_ready`=0 while the buffer is full.
- `rst` pulsed in cycle 2 of a length-5 press with a buffered request:
  - `y`=0 from the next cycle;
  - no `done`;
  - buffered request dropped;
  - `req_ready`=1.
- `rst` and `req_valid` high on the same edge: no press follows.
